// File: rtl/water_tank_pkg.sv
// Shared definitions for the water tank level path.
// Level codes are also used by the level column decoders.
package water_tank_pkg;

    localparam logic [1:0] LVL_FULL   = 2'b00;
    localparam logic [1:0] LVL_HIGH   = 2'b01;
    localparam logic [1:0] LVL_MEDIUM = 2'b10;
    localparam logic [1:0] LVL_EMPTY  = 2'b11;

    typedef enum logic [2:0] {
        ST_EMPTY  = 3'd0,
        ST_MEDIUM = 3'd1,
        ST_HIGH   = 3'd2,
        ST_FULL   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // Only a contiguous column of wet switches from the bottom is physical.
    function automatic logic vec_valid(input logic [2:0] v);
        return (v == 3'b000) || (v == 3'b001) ||
               (v == 3'b011) || (v == 3'b111);
    endfunction

    function automatic state_t vec_to_state(input logic [2:0] v);
        case (v)
            3'b001:  return ST_MEDIUM;
            3'b011:  return ST_HIGH;
            3'b111:  return ST_FULL;
            default: return ST_EMPTY;
        endcase
    endfunction

    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            ST_FULL:   return LVL_FULL;
            ST_HIGH:   return LVL_HIGH;
            ST_MEDIUM: return LVL_MEDIUM;
            default:   return LVL_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/water_tank_level_tracker_debouncer.sv
// Per-switch 2-flop synchronizer followed by a stability debouncer.
// The debounced value only moves after DEBOUNCE_CYCLES agreeing samples.
module sensor_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer for the asynchronous float switch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count disagreeing samples; accept the new value on the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/water_tank_level_tracker.sv
// Debounced float switches -> tank level code with fault detection.
// Impossible switch patterns hold the last level and may raise a fault.
module water_tank_level_tracker
    import water_tank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_low,
    input  logic       sensor_mid,
    input  logic       sensor_high,
    output logic [1:0] tank_level_status,
    output logic       sensor_fault,
    output logic       level_changed
);

    localparam int FW = $clog2(FAULT_CYCLES + 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FAULT_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_MAX  = FW'(FAULT_CYCLES);

    logic          db_low;
    logic          db_mid;
    logic          db_high;
    logic [2:0]    vec;
    logic          valid;
    logic [FW-1:0] fcnt;
    logic [1:0]    status_d1;
    state_t        state;
    state_t        state_next;

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_low (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_low),
        .level (db_low)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mid (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_mid),
        .level (db_mid)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_high (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_high),
        .level (db_high)
    );

    assign vec   = {db_high, db_mid, db_low};
    assign valid = vec_valid(vec);

    // Run length of invalid vectors, saturating at FAULT_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt <= '0;
        end else if (valid) begin
            fcnt <= '0;
        end else if (fcnt != FCNT_MAX) begin
            fcnt <= fcnt + FW'(1);
        end
    end

    // Level FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Valid vectors jump straight to their level; long invalid runs fault.
    always_comb begin
        state_next = state;
        if (valid) begin
            state_next = vec_to_state(vec);
        end else if (fcnt == FCNT_LAST) begin
            state_next = ST_FAULT;
        end
    end

    // Fault flag follows the FSM state directly.
    always_comb begin
        sensor_fault = (state == ST_FAULT);
    end

    // Registered level code; FAULT keeps the last level shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tank_level_status <= LVL_EMPTY;
        end else if (state != ST_FAULT) begin
            tank_level_status <= state_code(state);
        end
    end

    // One-cycle pulse the cycle after the level code changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_d1     <= LVL_EMPTY;
            level_changed <= 1'b0;
        end else begin
            status_d1     <= tank_level_status;
            level_changed <= (tank_level_status != status_d1);
        end
    end

endmodule

// File: tb/tb_water_tank_level_tracker.sv
// Scoreboard bench for water_tank_level_tracker.
// A window-based switch model predicts every cycle's outputs.
module tb_water_tank_level_tracker;

    localparam int DEB = 4;
    localparam int FLT = 8;

    typedef struct {
        logic [1:0] st;
        logic       f;
        logic       ch;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       raw_low = 1'b0;
    logic       raw_mid = 1'b0;
    logic       raw_high = 1'b0;
    logic [1:0] tank_level_status;
    logic       sensor_fault;
    logic       level_changed;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    exp_t exp_q[$];

    // Model state: raw sample history, debounced bits, level/fault view.
    bit   hist [3][DEB+2];
    bit   m_db [3];
    int   m_lvl;
    bit   m_flt;
    int   m_inv;
    int   m_status;
    int   m_status_d1;

    water_tank_level_tracker #(
        .DEBOUNCE_CYCLES(DEB),
        .FAULT_CYCLES   (FLT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sensor_low       (raw_low),
        .sensor_mid       (raw_mid),
        .sensor_high      (raw_high),
        .tank_level_status(tank_level_status),
        .sensor_fault     (sensor_fault),
        .level_changed    (level_changed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            m_db[i] = 1'b0;
            for (int k = 0; k < DEB + 2; k++) hist[i][k] = 1'b0;
        end
        m_lvl       = 3;
        m_flt       = 1'b0;
        m_inv       = 0;
        m_status    = 3;
        m_status_d1 = 3;
        exp_q.delete();
        e.st = 2'b11;
        e.f  = 1'b0;
        e.ch = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        exp_t e;
        bit   raw [3];
        bit   ch;
        int   ones;
        int   vec;
        bit   all_flip;
        raw[0] = raw_low;
        raw[1] = raw_mid;
        raw[2] = raw_high;
        ch = (m_status != m_status_d1);
        m_status_d1 = m_status;
        m_status = m_lvl;
        vec  = 4 * int'(m_db[2]) + 2 * int'(m_db[1]) + int'(m_db[0]);
        ones = int'(m_db[0]) + int'(m_db[1]) + int'(m_db[2]);
        if (vec == (1 << ones) - 1) begin
            m_lvl = 3 - ones;
            m_flt = 1'b0;
            m_inv = 0;
        end else begin
            m_inv++;
            if (m_inv >= FLT) m_flt = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < DEB + 1; k++) hist[i][k] = hist[i][k+1];
            hist[i][DEB+1] = raw[i];
            all_flip = 1'b1;
            for (int k = 0; k < DEB; k++)
                if (hist[i][k] == m_db[i]) all_flip = 1'b0;
            if (all_flip) m_db[i] = ~m_db[i];
        end
        e.st = 2'(m_status);
        e.f  = m_flt;
        e.ch = ch;
        exp_q.push_back(e);
    endtask

    // Reference model advances on the same events as the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // Monitor: compare every presented cycle against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (tank_level_status !== e.st || sensor_fault !== e.f ||
                level_changed !== e.ch) begin
                n_err++;
                $display("FAIL cycle @%0t: got st=%b f=%b ch=%b expected st=%b f=%b ch=%b",
                         $time, tank_level_status, sensor_fault, level_changed,
                         e.st, e.f, e.ch);
            end
        end
        if (level_changed === 1'b1) pulses++;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [2:0] v);
        raw_high = v[2];
        raw_mid  = v[1];
        raw_low  = v[0];
    endtask

    task automatic hold(input logic [2:0] v, input int n);
        drive(v);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("reset_status", int'(tank_level_status), 3);
        chk("reset_fault", int'(sensor_fault), 0);
        chk("reset_changed", int'(level_changed), 0);
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int p0;
        logic [2:0] v;
        logic [2:0] g;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Fill sequence with exactly three level pulses.
        p0 = pulses;
        hold(3'b000, 20);
        hold(3'b001, 20);
        hold(3'b011, 20);
        hold(3'b111, 20);
        chk("fill_pulses", pulses - p0, 3);
        chk("fill_final", int'(tank_level_status), 0);

        // Reset mid-run with switches full.
        drive(3'b111);
        do_reset(2);
        p0 = pulses;
        hold(3'b111, 20);
        chk("post_reset_pulses", pulses - p0, 1);
        chk("post_reset_status", int'(tank_level_status), 0);

        // Multi-step drop.
        p0 = pulses;
        hold(3'b000, 20);
        chk("drop_pulses", pulses - p0, 1);
        chk("drop_status", int'(tank_level_status), 3);

        // Short glitch then a real rise on the low switch.
        p0 = pulses;
        hold(3'b001, 3);
        hold(3'b000, 20);
        chk("glitch_pulses", pulses - p0, 0);
        hold(3'b001, 20);
        chk("debounce_status", int'(tank_level_status), 2);

        // Fault entry and recovery from MEDIUM.
        hold(3'b100, 30);
        chk("fault_flag", int'(sensor_fault), 1);
        chk("fault_status", int'(tank_level_status), 2);
        p0 = pulses;
        hold(3'b011, 20);
        chk("recover_flag", int'(sensor_fault), 0);
        chk("recover_status", int'(tank_level_status), 1);
        chk("recover_pulses", pulses - p0, 1);

        // Transient invalid: high leads mid by three cycles.
        hold(3'b001, 20);
        hold(3'b101, 3);
        hold(3'b111, 20);
        chk("transient_status", int'(tank_level_status), 0);

        // Randomized patterns, glitches and occasional resets.
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 9))
                0: v = 3'($urandom_range(0, 7));
                1: begin
                    do_reset($urandom_range(1, 3));
                    v = 3'($urandom_range(0, 7));
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: v = 3'b000;
                        1: v = 3'b001;
                        2: v = 3'b011;
                        default: v = 3'b111;
                    endcase
                end
            endcase
            hold(v, $urandom_range(1, 25));
            if ($urandom_range(0, 3) == 0) begin
                g = v ^ (3'b001 << $urandom_range(0, 2));
                hold(g, $urandom_range(1, DEB + 1));
                hold(v, $urandom_range(1, 12));
            end
        end
        hold(3'b111, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/water_tank_level_tracker.md
# water_tank_level_tracker

Converts the three raw float-switch inputs of the irrigation water tank into the 2-bit `tank_level_status` code consumed by the LED-matrix water tank level column decoders. Each switch is synchronized and debounced. A level FSM then rejects physically impossible switch combinations and holds the last good level, raising a fault flag while the combination stays invalid. The block sits directly upstream of the level column decoders and also feeds the pump/irrigation controller.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles a synchronized switch value needs before it is accepted (≥1).
- `FAULT_CYCLES`, default 8: consecutive cycles an invalid debounced combination must persist before FAULT is entered (≥1).
- `clk` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `sensor_low` input 1: raw float switch at the low mark; 1 means water is at or above the mark. Asynchronous to `clk`.
- `sensor_mid` input 1: raw float switch at the mid mark. Asynchronous.
- `sensor_high` input 1: raw float switch at the high mark. Asynchronous.
- `tank_level_status` output 2: level code; 2'b00 FULL, 2'b01 HIGH, 2'b10 MEDIUM, 2'b11 EMPTY.
- `sensor_fault` output 1: 1 while the FSM is in FAULT.
- `level_changed` output 1: one-cycle pulse in the cycle after `tank_level_status` takes a new value.

## Operation
- **Synchronizer:** 2-flop chain per switch.
- **Debouncer:** per-switch counter compared against the debounced value.
  - Counter clears whenever the synchronized value equals the debounced value.
  - Otherwise the counter increments.
  - When the count would reach `DEBOUNCE_CYCLES`, the debounced value takes the synchronized value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the debounced value.
- **Valid debounced vectors {high,mid,low}:**
  - 000 maps to EMPTY.
  - 001 maps to MEDIUM.
  - 011 maps to HIGH.
  - 111 maps to FULL.
  - All other vectors are invalid.
- **FSM states:** EMPTY, MEDIUM, HIGH, FULL, FAULT.
  - In any level state, a valid vector moves the FSM to the mapped state. Jumps of more than one step are allowed.
  - An invalid vector increments the fault counter. The level is held.
  - Once the counter reaches `FAULT_CYCLES`, the FSM enters FAULT.
  - A valid vector clears the fault counter.
  - In FAULT, `tank_level_status` holds the last valid level and `sensor_fault`=1.
  - FAULT is left for the mapped level state on the first valid vector. `sensor_fault` drops in the same edge.
- **Output:** `tank_level_status` is registered and encodes the current level state; in FAULT it keeps the last level code.
- **Level-change pulse:** `level_changed`=1 for exactly one cycle after each change of `tank_level_status`. There is no pulse on FAULT entry or exit if the level code is unchanged.

## Timing
- **Reset values (asynchronous):**
  - Sync flops, debounced values and all counters: 0.
  - FSM state: EMPTY.
  - `tank_level_status`=2'b11.
  - `sensor_fault`=0.
  - `level_changed`=0.
- **Latency:** a clean raw transition stable from edge t appears in `tank_level_status` at edge t+2+`DEBOUNCE_CYCLES`+1. This is 7 cycles at default. `level_changed` goes high one cycle later.
- **FAULT entry:** FAULT is reached `FAULT_CYCLES` edges after the debounced vector first becomes invalid.
- **Simultaneous switch changes:** each switch debounces independently, so transient invalid vectors can occur. These are absorbed by the fault counter and do not fault while shorter than `FAULT_CYCLES`.
- **Reset mid-debounce or mid-fault-count:** all progress is discarded, and the block restarts from the EMPTY reset state.
- **Counter widths:** each counter is $clog2(parameter+1) bits and saturates; it never wraps.

## Structure
- **Shared package/header `water_tank_pkg`:** level code constants (FULL/HIGH/MEDIUM/EMPTY) shared with the level column decoders, plus the FSM state encoding.
- **Sub-module `sensor_debouncer`:** parameterized by `DEBOUNCE_CYCLES`, containing the synchronizer and counter. Instantiated three times.
- The FSM, fault counter and output registers live in the top module.

## Test plan
- **Reset:** assert `reset` mid-run with switches 111. Required: `tank_level_status`=11 and `sensor_fault`=0 immediately. After release, with 111 held, `tank_level_status`=00 seven cycles later and `level_changed` pulses once.
- **Debounce:** pulse `sensor_low` for 3 cycles (`DEBOUNCE_CYCLES`=4). Required: no output change. Hold it for 4+ cycles: required `tank_level_status`=10.
- **Fill sequence:** switch vector 000 → 001 → 011 → 111, each step held 20 cycles. Required: status 11 → 10 → 01 → 00, with exactly three `level_changed` pulses.
- **Fault:** from MEDIUM apply vector 100, held. Required: `sensor_fault`=1 exactly 8 cycles after the debounced vector goes invalid, and status stays 10. Then apply 011: required status 01, `sensor_fault`=0 and one `level_changed` pulse.
- **Transient invalid:** 001 → 111 with `sensor_high` leading `sensor_mid` by 3 cycles. Required: no fault and the final status 00.
- **Multi-step drop:** 111 → 000. Required: status goes 00 → 11 directly, with a single `level_changed` pulse.
